// File: rtl/aes192_mode_ctrl.sv
// CBC/ECB initiator for aes192_core. It loads the key and IV, waits for
// key expansion, then moves one 128-bit block at a time through the core.
module aes192_mode_ctrl #(
  parameter bit CBC_EN = 1'b1,
  parameter int TMO    = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_mode,
  input  logic [191:0] i_key,
  input  logic [127:0] i_iv,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_err,
  input  logic [127:0] i_blk,
  input  logic         i_blk_vld,
  output logic         o_blk_rdy,
  output logic [127:0] o_blk,
  output logic         o_blk_vld,
  input  logic         i_blk_rdy,
  output logic         o_core_flag,
  output logic [191:0] o_core_key,
  output logic         o_core_key_en,
  input  logic         i_core_key_ok,
  output logic [127:0] o_core_din,
  output logic         o_core_din_en,
  input  logic [127:0] i_core_dout,
  input  logic         i_core_dout_en
);

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, RUN, OUT} state_t;

  // Wide enough to hold TMO plus the two-cycle key_ok blanking window
  localparam int CW = $clog2(TMO + 3);

  state_t         state_q, state_d;
  logic           mode_q, mode_d;
  logic [191:0]   key_q, key_d;
  logic [127:0]   chain_q, chain_d;
  logic [127:0]   saved_q, saved_d;
  logic [127:0]   blk_d, din_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           key_en_d, din_en_d, err_d;
  logic [127:0]   chain_term;

  // In ECB builds the chaining XOR collapses to zero
  assign chain_term = CBC_EN ? chain_q : '0;

  assign o_core_flag = mode_q;
  assign o_core_key  = key_q;

  // Next-state and datapath decisions; start handling is shared by IDLE and READY
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    key_d    = key_q;
    chain_d  = chain_q;
    saved_d  = saved_q;
    blk_d    = o_blk;
    din_d    = o_core_din;
    cnt_d    = cnt_q;
    key_en_d = 1'b0;
    din_en_d = 1'b0;
    err_d    = 1'b0;

    if ((state_q == IDLE || state_q == READY) && i_start) begin
      mode_d   = i_mode;
      key_d    = i_key;
      chain_d  = i_iv;
      key_en_d = 1'b1;
      cnt_d    = '0;
      state_d  = KEYEXP;
    end else begin
      case (state_q)
        KEYEXP: begin
          if (cnt_q >= CW'(2) && i_core_key_ok) begin
            state_d = READY;
          end else if (cnt_q >= CW'(TMO)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        READY: begin
          if (i_blk_vld) begin
            din_d    = i_mode_sel(mode_q) ? (i_blk ^ chain_term) : i_blk;
            if (!mode_q) saved_d = i_blk;
            din_en_d = 1'b1;
            cnt_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (i_core_dout_en) begin
            blk_d   = mode_q ? i_core_dout : (i_core_dout ^ chain_term);
            chain_d = mode_q ? i_core_dout : saved_q;
            state_d = OUT;
          end else if (cnt_q >= CW'(TMO)) begin
            err_d   = 1'b1;
            state_d = READY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        OUT: begin
          if (i_blk_rdy) state_d = READY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  function automatic logic i_mode_sel(input logic m);
    return m;
  endfunction

  // State, datapath and fully registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      key_q         <= '0;
      chain_q       <= '0;
      saved_q       <= '0;
      cnt_q         <= '0;
      o_blk         <= '0;
      o_core_din    <= '0;
      o_core_key_en <= 1'b0;
      o_core_din_en <= 1'b0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
      o_blk_rdy     <= 1'b0;
      o_blk_vld     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      key_q         <= key_d;
      chain_q       <= chain_d;
      saved_q       <= saved_d;
      cnt_q         <= cnt_d;
      o_blk         <= blk_d;
      o_core_din    <= din_d;
      o_core_key_en <= key_en_d;
      o_core_din_en <= din_en_d;
      o_err         <= err_d;
      o_busy        <= (state_d != IDLE) && (state_d != READY);
      o_blk_rdy     <= (state_d == READY);
      o_blk_vld     <= (state_d == OUT);
    end
  end

endmodule

// File: doc/aes192_mode_ctrl.md
# aes192_mode_ctrl

Host-side initiator for `aes192_core`. It loads a 192-bit key and a 128-bit IV, triggers core key expansion, then streams 128-bit blocks through the core over valid/ready handshakes. It applies CBC chaining, or ECB when chaining is disabled. It sits between a bus/DMA front end and the core and owns the core's `i_flag`, `i_key*` and `i_din*` inputs, keeping one block in flight at a time.

## Interface
- `CBC_EN`, default 1: 1 selects CBC chaining; 0 selects ECB (chain XOR bypassed).
- `TMO`, default 255: maximum cycles to wait for `i_core_key_ok` or `i_core_dout_en` before aborting.
- `i_clk` input 1: clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_mode` input 1: 1 = encrypt, 0 = decrypt. Sampled on `i_start`.
- `i_key` input 192: key. Sampled on `i_start`.
- `i_iv` input 128: IV. Sampled on `i_start`.
- `i_start` input 1: load key/IV and start key expansion.
- `o_busy` output 1: high in every state except IDLE and READY.
- `o_err` output 1: one-cycle pulse on timeout.
- `i_blk` input 128: input block.
- `i_blk_vld` input 1: input block valid.
- `o_blk_rdy` output 1: ready to accept an input block.
- `o_blk` output 128: result block.
- `o_blk_vld` output 1: result block valid.
- `i_blk_rdy` input 1: downstream accepts the result block.
- `o_core_flag` output 1: drives core `i_flag`.
- `o_core_key` output 192: drives core `i_key`.
- `o_core_key_en` output 1: drives core `i_key_en`.
- `i_core_key_ok` input 1: from core `o_key_ok`.
- `o_core_din` output 128: drives core `i_din`.
- `o_core_din_en` output 1: drives core `i_din_en`.
- `i_core_dout` input 128: from core `o_dout`.
- `i_core_dout_en` input 1: from core `o_dout_en`.

## Operation
- **Reset values:** state IDLE. All 1-bit outputs 0. All data outputs and internal registers (key, chain, saved-input) 0.
- **FSM states:** IDLE, KEYEXP, READY, RUN, OUT.
- **IDLE**
  - On `i_start`: latch mode, key and IV; chain <= IV; pulse `o_core_key_en` for one cycle; go to KEYEXP.
- **KEYEXP**
  - `i_core_key_ok` is ignored during the pulse cycle and the cycle after it.
  - Afterwards, `i_core_key_ok`=1 moves the FSM to READY.
- **READY**
  - `o_blk_rdy`=1.
  - On `i_blk_vld & o_blk_rdy`, go to RUN and drive the core for one cycle:
    - encrypt: `o_core_din` = blk ^ chain;
    - decrypt: `o_core_din` = blk, and saved <= blk.
  - With CBC_EN=0, the XOR term is 0.
  - `i_start` in READY restarts as from IDLE. It takes priority over a simultaneous `i_blk_vld`, and the block is not accepted.
- **RUN**
  - Waits for `i_core_dout_en`, then captures the result:
    - encrypt: `o_blk` = dout, chain <= dout;
    - decrypt: `o_blk` = dout ^ chain, chain <= saved.
  - Then go to OUT.
- **OUT**
  - `o_blk_vld`=1; `o_blk` is held stable until `i_blk_rdy`, then go to READY.
- **Stray events:** `i_core_dout_en` outside RUN and `i_core_key_ok` outside KEYEXP are ignored. `i_start` outside IDLE/READY is ignored.
- **Timeout:**
  - A counter clears on entry to KEYEXP or RUN and saturates at TMO.
  - Reaching TMO without the awaited event pulses `o_err` for one cycle.
  - From KEYEXP the FSM goes to IDLE. From RUN it goes to READY with the chain unchanged and no output.
- **Fixed outputs:** `o_core_flag` = latched mode at all times. `o_core_key` = latched key.
- **Reset mid-operation:** immediate return to reset values. Any core result in flight afterwards is ignored.

## Timing
- **`i_start`:** sampled in cycle N; `o_core_key_en`=1 in cycle N+1 only.
- **Key ready:** READY, with `o_blk_rdy`=1, in the cycle after `i_core_key_ok` is first qualified high.
- **Block issue:** input handshake in cycle N; `o_core_din_en`=1 with valid `o_core_din` in cycle N+1. `o_blk_rdy`=0 from N+1.
- **Result:** `i_core_dout_en` in cycle M; `o_blk_vld`=1 in cycle M+1.
- **Return to READY:** output handshake in cycle K; `o_blk_rdy`=1 in cycle K+1.
- **Throughput:** one block per (core latency + 3) cycles when downstream is always ready.
- **Registered outputs:** all outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Encrypt, first block:** CBC_EN=1, key 000102…1617, IV 0, encrypt pt 00112233445566778899aabbccddeeff -> `o_blk` = dda97ca4864cdfe06eaf70a0ec0d7191. `o_core_key_en` is exactly one cycle wide.
- **Decrypt, first block:** same key and IV, decrypt ct dda97ca4864cdfe06eaf70a0ec0d7191 -> `o_blk` = 00112233445566778899aabbccddeeff.
- **CBC chaining:** encrypt that pt twice in CBC -> second core input = pt ^ dda97ca4…; decrypting both outputs returns pt twice. ECB build (CBC_EN=0) -> identical ciphertext for both blocks.
- **Backpressure:** hold `i_blk_rdy`=0 for 20 cycles in OUT -> `o_blk` stable, `o_blk_rdy`=0, no `o_core_din_en`. A stray `i_core_dout_en` pulse in that window is ignored.
- **Timeout:** stub core never asserts `i_core_dout_en` -> exactly one `o_err` pulse TMO cycles after issue; FSM in READY; chain unchanged (next block still uses the prior chain).
- **Reset and priority:** assert `i_rst` in RUN -> all outputs 0 asynchronously and FSM in IDLE. Simultaneous `i_start` and `i_blk_vld` in READY -> key reloaded, block not accepted.
